// File: rtl/fifo_drain_serializer.sv
// fifo_drain_serializer: pops wide words from a 2-entry FIFO dequeue port and
// streams them out as narrow valid/ready beats, reloading the next word on the
// final beat's handshake so consecutive words leave with no idle cycle.
// Optional build macro FIFO_DRAIN_MSB_FIRST_EN: emit beats most-significant
// first instead of the default least-significant first.
module fifo_drain_serializer #(
  parameter int width      = 32,
  parameter int beat_width = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  EMPTY_N,
  input  logic [width-1:0]      D_IN,
  output logic                  DEQ,
  input  logic                  CLR,
  output logic                  OUT_VALID,
  output logic [beat_width-1:0] OUT_DATA,
  output logic                  OUT_LAST,
  input  logic                  OUT_RDY
);

  localparam int N  = width / beat_width;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [CW-1:0]         r_cnt;
  logic [CW-1:0]         w_cnt_next;
  logic [width-1:0]      r_shreg;
  logic [width-1:0]      w_shreg_next;
  logic [width-1:0]      w_shreg_shifted;
  logic [beat_width-1:0] w_beat;
  logic                  w_last;
  logic                  w_accept;
  logic                  w_load;

  // Beat ordering: the beat on the wire is always the end of shreg that the
  // shift moves away from, so a word needs no separate beat index mux.
`ifdef FIFO_DRAIN_MSB_FIRST_EN
  assign w_beat          = r_shreg[width-1 -: beat_width];
  assign w_shreg_shifted = r_shreg << beat_width;
`else
  assign w_beat          = r_shreg[beat_width-1:0];
  assign w_shreg_shifted = r_shreg >> beat_width;
`endif

  assign w_last   = (r_cnt == LAST_CNT);
  assign w_accept = (r_state == S_SHIFT) && OUT_RDY;
  // A word is taken when idle, or when the final beat of the current word is
  // handed off in this cycle; a clear always wins over a reload.
  assign w_load   = EMPTY_N && !CLR && ((r_state == S_IDLE) || (w_accept && w_last));

  // State register with the beat counter and shift register alongside it.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_shreg <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_shreg <= w_shreg_next;
    end
  end

  // Next-state logic: clear, then reload, then advance on an accepted beat.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_shreg_next = r_shreg;
    if (CLR) begin
      w_state_next = S_IDLE;
      w_cnt_next   = '0;
      w_shreg_next = '0;
    end else if (w_load) begin
      w_state_next = S_SHIFT;
      w_cnt_next   = '0;
      w_shreg_next = D_IN;
    end else if (w_accept) begin
      if (w_last) begin
        w_state_next = S_IDLE;
      end else begin
        w_cnt_next   = r_cnt + 1'b1;
        w_shreg_next = w_shreg_shifted;
      end
    end
  end

  // Outputs: beat signals follow the registered state only; DEQ is held low
  // while reset is asserted so the FIFO is never popped during reset.
  always_comb begin
    DEQ       = 1'b0;
    OUT_VALID = 1'b0;
    OUT_DATA  = '0;
    OUT_LAST  = 1'b0;
    if (RST) begin
      DEQ = w_load;
    end
    if (r_state == S_SHIFT) begin
      OUT_VALID = 1'b1;
      OUT_DATA  = w_beat;
      OUT_LAST  = w_last;
    end
  end

endmodule

// File: tb/tb_fifo_drain_serializer.sv
// tb_fifo_drain_serializer: drives the serializer from a queue-modelled 2-entry
// FIFO and compares every cycle against a beat-stream scoreboard built from the
// words that were popped.
module tb_fifo_drain_serializer;

  localparam int W  = 32;
  localparam int BW = 8;
  localparam int N  = W / BW;

  typedef struct {
    logic [BW-1:0] data;
    bit            last;
  } beat_t;

  logic          CLK;
  logic          RST;
  logic          EMPTY_N;
  logic [W-1:0]  D_IN;
  logic          DEQ;
  logic          CLR;
  logic          OUT_VALID;
  logic [BW-1:0] OUT_DATA;
  logic          OUT_LAST;
  logic          OUT_RDY;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] fifo_q[$];
  beat_t        exp_q[$];

  fifo_drain_serializer #(.width(W), .beat_width(BW)) dut (
    .CLK(CLK),
    .RST(RST),
    .EMPTY_N(EMPTY_N),
    .D_IN(D_IN),
    .DEQ(DEQ),
    .CLR(CLR),
    .OUT_VALID(OUT_VALID),
    .OUT_DATA(OUT_DATA),
    .OUT_LAST(OUT_LAST),
    .OUT_RDY(OUT_RDY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle, entered just after a falling edge. The expected DEQ is
  // derived from the stream: pop whenever nothing of the current word remains
  // after this cycle and the FIFO has a word, unless clearing.
  task automatic do_cycle(input bit rdy, input bit clr);
    bit           en;
    bit           exp_deq;
    logic [W-1:0] dword;
    beat_t        b;
    en      = (fifo_q.size() != 0);
    EMPTY_N = en;
    D_IN    = en ? fifo_q[0] : W'($urandom);
    OUT_RDY = rdy;
    CLR     = clr;
    #1;
    exp_deq = en && !clr && ((exp_q.size() == 0) || (exp_q.size() == 1 && rdy));
    chk("deq", DEQ, exp_deq);
    chk("valid", OUT_VALID, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      chk("data", OUT_DATA, exp_q[0].data);
      chk("last", OUT_LAST, exp_q[0].last);
    end
    if (OUT_VALID && rdy)
      $display("beat  data=0x%02h last=%0b clr=%0b t=%0t", OUT_DATA, OUT_LAST, clr, $time);
    if (clr) begin
      exp_q.delete();
    end else begin
      if (exp_q.size() != 0 && rdy) void'(exp_q.pop_front());
      if (DEQ && en) begin
        dword = fifo_q.pop_front();
        $display("deq   word=0x%08h t=%0t", dword, $time);
        for (int k = 0; k < N; k++) begin
`ifdef FIFO_DRAIN_MSB_FIRST_EN
          b.data = dword[(N-1-k)*BW +: BW];
`else
          b.data = dword[k*BW +: BW];
`endif
          b.last = (k == N - 1);
          exp_q.push_back(b);
        end
      end
    end
    @(negedge CLK);
  endtask

  initial begin
    int budget;
    RST     = 1'b0;
    EMPTY_N = 1'b0;
    D_IN    = '0;
    CLR     = 1'b0;
    OUT_RDY = 1'b0;
    #1;
    chk("reset_valid", OUT_VALID, 0);
    chk("reset_last", OUT_LAST, 0);
    chk("reset_data", OUT_DATA, 0);
    chk("reset_deq", DEQ, 0);
    @(negedge CLK);
    RST = 1'b1;

    // Single word, free-flowing output.
    fifo_q.push_back(32'h44332211);
    repeat (7) do_cycle(1, 0);

    // Two words back to back: second pop on acceptance of the last beat.
    fifo_q.push_back(32'hAABBCCDD);
    fifo_q.push_back(32'h01020304);
    repeat (11) do_cycle(1, 0);

    // Backpressure on the third beat.
    fifo_q.push_back(32'h44332211);
    do_cycle(1, 0); do_cycle(1, 0); do_cycle(1, 0);
    do_cycle(0, 0); do_cycle(0, 0); do_cycle(0, 0);
    repeat (4) do_cycle(1, 0);

    // Clear after the second beat while another word waits in the FIFO.
    fifo_q.push_back(32'h44332211);
    do_cycle(1, 0); do_cycle(1, 0); do_cycle(1, 0);
    fifo_q.push_back(32'h55667788);
    do_cycle(1, 1);
    repeat (7) do_cycle(1, 0);

    // Asynchronous reset between clock edges in the middle of a word.
    fifo_q.push_back(32'h44332211);
    do_cycle(1, 0); do_cycle(1, 0);
    fifo_q.push_back(32'h99887766);
    EMPTY_N = 1'b1;
    D_IN    = fifo_q[0];
    OUT_RDY = 1'b1;
    CLR     = 1'b0;
    #1;
    chk("pre_rst_valid", OUT_VALID, 1);
    #1;
    RST = 1'b0;
    #1;
    chk("rst_valid", OUT_VALID, 0);
    chk("rst_deq", DEQ, 0);
    chk("rst_data", OUT_DATA, 0);
    chk("rst_last", OUT_LAST, 0);
    exp_q.delete();
    fifo_q.delete();
    @(negedge CLK);
    RST = 1'b1;
    repeat (4) do_cycle(1, 0);

    // Randomized traffic, backpressure and occasional clears.
    for (int c = 0; c < 1500; c++) begin
      if (fifo_q.size() < 2 && $urandom_range(0, 3) != 0) fifo_q.push_back($urandom);
      do_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
    end

    // Drain everything that is still pending, with a bounded cycle budget.
    budget = 0;
    while ((exp_q.size() != 0 || fifo_q.size() != 0) && budget < 50) begin
      do_cycle(1, 0);
      budget++;
    end
    chk("drain_done", (exp_q.size() == 0 && fifo_q.size() == 0), 1);
    repeat (3) do_cycle(1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
